decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage sitting between the fetch buffer and register read/issue. It accepts one 32-bit instruction per cycle over a valid/ready handshake, decodes register fields, format, an XLEN-wide immediate, and register-use/illegal flags, and presents them one cycle later on a valid/ready output port. It handles downstream backpressure and flush without loss or duplication.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards every held entry.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address, carried through.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  carried PC.
- out_op  out  7  inst[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], [19:15], [24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5.
- out_imm  out  XLEN  decoded immediate.
- out_rs1_used, out_rs2_used, out_rd_we  out  1 each  operand/writeback flags.
- out_illegal  out  1  instruction not legal for XLEN.

## Operation
- Handshake: transfer on valid && ready, both ports. out_* data stable while out_valid && !out_ready.
- Immediates, always sign-extended from bit 31 to XLEN unless stated:
  - I (LOAD, JALR, OP_IMM non-shift incl. SLTIU): inst[31:20].
  - OP_IMM shifts (funct3 001/101): zero-extended shamt inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64); funct7 bits excluded.
  - S: {inst[31:25], inst[11:7]}. B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}. J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - U (LUI, AUIPC): {inst[31:12], 12'b0}, sign-extended to XLEN.
  - R, FENCE, SYSTEM, illegal: 0.
- Illegal when: inst[1:0] != 11; opcode outside LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM; JALR funct3 != 0; BRANCH funct3 010/011; LOAD funct3 111, or 011/110 with XLEN=32; STORE funct3 >= 100, or 011 with XLEN=32; OP funct7 not 0000000, or 0100000 outside funct3 000/101; OP_IMM SLLI funct7 != 0, SRLI/SRAI upper bits not 0000000/0100000 (XLEN=64 checks inst[31:26]); XLEN=32 shift with inst[25]=1.
- Flags: rs1_used for all except LUI, AUIPC, JAL, MISC_MEM, SYSTEM; rs2_used for R, S, B; rd_we for R, I, U, J when rd != 0. Illegal forces all three to 0; fields still output raw.

## Timing
- Latency: accepted at edge N -> out_valid high after edge N, throughput 1/cycle.
- Reset (async, while rst high): out_valid=0, in_ready=0, all out data 0, skid empty. in_ready rises the first edge after rst deasserts.
- Without skid: in_ready = !rst && (!out_valid || out_ready) — combinational through out_ready.
- flush: at next edge out_valid=0 and skid empty; an input handshake in the flush cycle is dropped. flush with out_ready in the same cycle: output entry counts as transferred; nothing new loaded.
- rst asserted mid-transfer: entry lost, outputs clear immediately.

## Configuration
- DECODE_SKID_EN defined: two-entry buffer (output register + skid register); in_ready is a flop = skid empty, no combinational path out_ready -> in_ready. Accept while output held stores into skid; on output transfer, skid moves to output same edge. Order strictly preserved.
- Undefined: single output register, combinational in_ready as above.

## Test plan
- addi x1,x0,5 (0x00500093), pc 0x100 -> one cycle later out_valid, fmt=1, rd=1, imm=5, rd_we=1, rs2_used=0, out_pc=0x100.
- 0xFFF00113, 0xFFC080E7, 0x4010D093 -> imm all-ones, 0xFFFFFFFC (sign-extended to XLEN), 1; XLEN=64 LUI 0x800000B7 -> imm 0xFFFFFFFF80000000.
- Stream 5 instructions, out_ready low cycles 2-4 -> all 5 out once, in order; with DECODE_SKID_EN in_ready low exactly while skid full.
- 0x00000000 -> illegal=1, rd_we=0; 0x00000033 (add x0) -> illegal=0, rd_we=0; XLEN=32 0x02009093 (slli shamt 32) -> illegal=1.
- Flush with output and skid full -> out_valid=0 next cycle, next accepted instruction appears alone.
- rst pulsed mid-stream, not on an edge -> out_valid drops immediately; in_ready 0 until first edge after release.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I/RV64I decode stage with valid/ready ports
// Optional two-entry output buffering under DECODE_SKID_EN.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    entry_t          w_dec;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [5:0]      w_shamt;
    logic [2:0]      w_fmt;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_shift;
    logic            w_ill;
    logic            w_rs1u;
    logic            w_rs2u;
    logic            w_wb_fmt;
    logic            w_accept;
    logic            w_out_fire;

    entry_t          r_out;
    logic            r_out_valid;

    assign w_f3    = in_inst[14:12];
    assign w_f7    = in_inst[31:25];
    assign w_shamt = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_R;
        w_shift = 1'b0;
        w_ill   = 1'b0;
        w_rs1u  = 1'b0;
        w_rs2u  = 1'b0;
        case (in_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_fmt   = FMT_U;
                w_imm32 = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_fmt   = FMT_J;
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_fmt   = FMT_I;
                w_rs1u  = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_ill   = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_fmt   = FMT_B;
                w_rs1u  = 1'b1;
                w_rs2u  = 1'b1;
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                w_ill   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_LOAD: begin
                w_fmt   = FMT_I;
                w_rs1u  = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                w_ill   = (w_f3 == 3'b111) ||
                          ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
            end
            OPC_STORE: begin
                w_fmt   = FMT_S;
                w_rs1u  = 1'b1;
                w_rs2u  = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                w_ill   = w_f3[2] || ((XLEN == 32) && (w_f3 == 3'b011));
            end
            OPC_OP_IMM: begin
                w_fmt   = FMT_I;
                w_rs1u  = 1'b1;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                // RV64 shifts borrow inst[25] for shamt, so only inst[31:26] is checked there
                if (w_f3 == 3'b001) begin
                    w_shift = 1'b1;
                    w_ill   = (XLEN == 64) ? (in_inst[31:26] != 6'b000000) : (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_shift = 1'b1;
                    if (XLEN == 64)
                        w_ill = (in_inst[31:26] != 6'b000000) && (in_inst[31:26] != 6'b010000);
                    else
                        w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                w_fmt  = FMT_R;
                w_rs1u = 1'b1;
                w_rs2u = 1'b1;
                if (w_f7 == 7'b0100000)
                    w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                else
                    w_ill = (w_f7 != 7'b0000000);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                w_fmt = FMT_I;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_imm        = {XLEN{w_imm32[31]}};
        w_imm[31:0]  = w_imm32;
        if (w_shift) begin
            w_imm      = '0;
            w_imm[5:0] = w_shamt;
        end
        if (w_ill || (in_inst[6:0] == OPC_MISC_MEM) || (in_inst[6:0] == OPC_SYSTEM))
            w_imm = '0;
    end

    assign w_wb_fmt = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = in_pc;
        w_dec.op       = in_inst[6:0];
        w_dec.rd       = in_inst[11:7];
        w_dec.rs1      = in_inst[19:15];
        w_dec.rs2      = in_inst[24:20];
        w_dec.funct3   = w_f3;
        w_dec.funct7   = w_f7;
        w_dec.fmt      = w_fmt;
        w_dec.imm      = w_imm;
        w_dec.illegal  = w_ill;
        w_dec.rs1_used = w_rs1u && !w_ill;
        w_dec.rs2_used = w_rs2u && !w_ill;
        w_dec.rd_we    = w_wb_fmt && (in_inst[11:7] != 5'd0) && !w_ill;
    end

    assign w_accept   = in_valid && in_ready && !flush;
    assign w_out_fire = r_out_valid && out_ready;

`ifdef DECODE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;

    // in_ready is registered: it mirrors "skid empty" as of the next edge
    assign in_ready = r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_out_fire) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_out <= w_dec;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (r_out_valid) begin
                    r_skid       <= w_dec;
                    r_skid_valid <= 1'b1;
                end else begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end
            end
            if (!w_out_fire)
                r_in_ready <= !(r_skid_valid || (w_accept && r_out_valid));
        end
    end
`else
    logic r_rdy_en;

    assign in_ready = r_rdy_en && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

    assign out_valid    = r_out_valid;
    assign out_pc       = r_out.pc;
    assign out_op       = r_out.op;
    assign out_rd       = r_out.rd;
    assign out_rs1      = r_out.rs1;
    assign out_rs2      = r_out.rs2;
    assign out_funct3   = r_out.funct3;
    assign out_funct7   = r_out.funct7;
    assign out_fmt      = r_out.fmt;
    assign out_imm      = r_out.imm;
    assign out_rs1_used = r_out.rs1_used;
    assign out_rs2_used = r_out.rs2_used;
    assign out_rd_we    = r_out.rd_we;
    assign out_illegal  = r_out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage (XLEN 32 and 64 instances)
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc32;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        rdy32, ov32, r1u32, r2u32, we32, ill32;
    logic [31:0] pc32, imm32;
    logic [6:0]  op32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;

    logic        rdy64, ov64, r1u64, r2u64, we64, ill64;
    logic [63:0] pc64, imm64;
    logic [6:0]  op64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_pc(in_pc32),
        .out_valid(ov32), .out_ready(out_ready), .out_pc(pc32), .out_op(op32),
        .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_funct3(f3_32),
        .out_funct7(f7_32), .out_fmt(fmt32), .out_imm(imm32),
        .out_rs1_used(r1u32), .out_rs2_used(r2u32), .out_rd_we(we32), .out_illegal(ill32)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_pc(in_pc64),
        .out_valid(ov64), .out_ready(out_ready), .out_pc(pc64), .out_op(op64),
        .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_funct3(f3_64),
        .out_funct7(f7_64), .out_fmt(fmt64), .out_imm(imm64),
        .out_rs1_used(r1u64), .out_rs2_used(r2u64), .out_rd_we(we64), .out_illegal(ill64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic        ill32;
        logic        ill64;
        logic        rs1u;
        logic        rs2u;
        logic        we;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_inst(input int idx);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'(idx);
        rd  = 5'(idx + 1);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t   v;
        logic [31:0] q_pc[$];
        logic [4:0]  q_rd[$];
        int     sent, got, occ;

        //                 inst          fmt   rd     imm32         imm64                    i32   i64   rs1u  rs2u  we
        vecs[0]  = '{32'h00500093, 3'd1, 5'd1,  32'h00000005, 64'h0000000000000005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'hFFF00113, 3'd1, 5'd2,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'hFFC080E7, 3'd1, 5'd1,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h4010D093, 3'd1, 5'd1,  32'h00000001, 64'h0000000000000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h800000B7, 3'd4, 5'd1,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h00000000, 3'd7, 5'd0,  32'h00000000, 64'h0000000000000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000033, 3'd0, 5'd0,  32'h00000000, 64'h0000000000000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h02009093, 3'd1, 5'd1,  32'h00000000, 64'h0000000000000020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h0020A423, 3'd2, 5'd8,  32'h00000008, 64'h0000000000000008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'hFE208EE3, 3'd3, 5'd29, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h001000EF, 3'd5, 5'd1,  32'h00000800, 64'h0000000000000800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h0000B083, 3'd1, 5'd1,  32'h00000000, 64'h0000000000000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h402081B3, 3'd0, 5'd3,  32'h00000000, 64'h0000000000000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{32'h402091B3, 3'd0, 5'd3,  32'h00000000, 64'h0000000000000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'hFFFFF297, 3'd4, 5'd5,  32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h00000073, 3'd1, 5'd0,  32'h00000000, 64'h0000000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{32'h4210D093, 3'd1, 5'd1,  32'h00000000, 64'h0000000000000021, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        in_pc32 = '0; in_pc64 = '0; out_ready = 1'b0;

        #12;
        chk("reset_out_valid", 64'(ov32), 64'd0);
        chk("reset_in_ready", 64'(rdy32), 64'd0);
        chk("reset_out_pc", 64'(pc32), 64'd0);
        chk("reset_out_imm", 64'(imm32), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_before_first_edge", 64'(rdy32), 64'd0);
        @(posedge clk);
        #1 chk("in_ready_after_first_edge", 64'(rdy32), 64'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            @(negedge clk);
            in_valid = 1'b1;
            in_inst  = v.inst;
            in_pc32  = 32'h100 + 32'(4 * i);
            in_pc64  = {32'h0, in_pc32};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(ov32), 64'd1);
            chk($sformatf("v%0d_pc", i), 64'(pc32), 64'(32'h100 + 32'(4 * i)));
            chk($sformatf("v%0d_op", i), 64'(op32), 64'(v.inst[6:0]));
            chk($sformatf("v%0d_rd", i), 64'(rd32), 64'(v.rd));
            chk($sformatf("v%0d_rs1", i), 64'(rs1_32), 64'(v.inst[19:15]));
            chk($sformatf("v%0d_rs2", i), 64'(rs2_32), 64'(v.inst[24:20]));
            chk($sformatf("v%0d_funct3", i), 64'(f3_32), 64'(v.inst[14:12]));
            chk($sformatf("v%0d_funct7", i), 64'(f7_32), 64'(v.inst[31:25]));
            if (v.fmt != 3'd7)
                chk($sformatf("v%0d_fmt", i), 64'(fmt32), 64'(v.fmt));
            chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(v.imm32));
            chk($sformatf("v%0d_illegal32", i), 64'(ill32), 64'(v.ill32));
            chk($sformatf("v%0d_rs1_used", i), 64'(r1u32), 64'(v.rs1u));
            chk($sformatf("v%0d_rs2_used", i), 64'(r2u32), 64'(v.rs2u));
            chk($sformatf("v%0d_rd_we", i), 64'(we32), 64'(v.we));
            chk($sformatf("v%0d_imm64", i), imm64, v.imm64);
            chk($sformatf("v%0d_illegal64", i), 64'(ill64), 64'(v.ill64));
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1 chk("drain_out_valid", 64'(ov32), 64'd0);

        // stream of five with out_ready low in stream cycles 2..4
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 5);
            in_inst   = addi_inst(sent);
            in_pc32   = 32'h200 + 32'(4 * sent);
            in_pc64   = {32'h0, in_pc32};
            #1;
            occ = q_pc.size();
            chk($sformatf("stream_c%0d_out_valid", c), 64'(ov32), 64'(occ > 0));
`ifdef DECODE_SKID_EN
            chk($sformatf("stream_c%0d_in_ready", c), 64'(rdy32), 64'(occ < 2));
`else
            chk($sformatf("stream_c%0d_in_ready", c), 64'(rdy32), 64'(occ == 0 || out_ready));
`endif
            if (ov32 && out_ready) begin
                if (occ > 0) begin
                    chk($sformatf("stream_out%0d_pc", got), 64'(pc32), 64'(q_pc.pop_front()));
                    chk($sformatf("stream_out%0d_rd", got), 64'(rd32), 64'(q_rd.pop_front()));
                end
                got++;
            end
            if (in_valid && rdy32) begin
                q_pc.push_back(in_pc32);
                q_rd.push_back(5'(sent + 1));
                sent++;
            end
            @(posedge clk);
        end
        chk("stream_count", 64'(got), 64'd5);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("stream_no_extra", 64'(ov32), 64'd0);

        // flush with the stage holding entries
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = addi_inst(6); in_pc32 = 32'h300; in_pc64 = 64'h300;
        @(posedge clk);
        #1 chk("flushseq_a_valid", 64'(ov32), 64'd1);
        @(negedge clk);
        in_inst = addi_inst(7); in_pc32 = 32'h304; in_pc64 = 64'h304;
        @(posedge clk);
        #1 chk("flushseq_hold_pc", 64'(pc32), 64'h300);
`ifdef DECODE_SKID_EN
        chk("flushseq_skid_full_in_ready", 64'(rdy32), 64'd0);
`endif
        @(negedge clk);
        flush = 1'b1; in_inst = addi_inst(8); in_pc32 = 32'h308; in_pc64 = 64'h308;
        @(posedge clk);
        #1 chk("flushseq_valid_cleared", 64'(ov32), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = addi_inst(9); in_pc32 = 32'h30C; in_pc64 = 64'h30C;
        @(posedge clk);
        #1;
        chk("flushseq_next_valid", 64'(ov32), 64'd1);
        chk("flushseq_next_pc", 64'(pc32), 64'h30C);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("flushseq_next_alone", 64'(ov32), 64'd0);

        // input handshake coinciding with flush is dropped
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_inst = addi_inst(10); in_pc32 = 32'h310; in_pc64 = 64'h310;
        @(posedge clk);
        #1 chk("flush_drops_input", 64'(ov32), 64'd0);
        flush = 1'b0; in_valid = 1'b0;

        // asynchronous reset mid-stream
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = addi_inst(11); in_pc32 = 32'h400; in_pc64 = 64'h400;
        @(posedge clk);
        #1 chk("rstseq_loaded", 64'(ov32), 64'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstseq_valid_drop", 64'(ov32), 64'd0);
        chk("rstseq_pc_clear", 64'(pc32), 64'd0);
        chk("rstseq_in_ready", 64'(rdy32), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstseq_in_ready_before_edge", 64'(rdy32), 64'd0);
        chk("rstseq_valid_after_release", 64'(ov32), 64'd0);
        @(posedge clk);
        #1 chk("rstseq_in_ready_after_edge", 64'(rdy32), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
